// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//
// Skid/queue buffer between instruction fetch and decode. Holds up to DEPTH
// fetched entries {pc, instr, misaligned} in a small circular buffer and
// presents the oldest one to decode. A flush (taken branch) empties the
// buffer and drops whatever fetch is presenting in that cycle.
//
// Parameters
//   DEPTH      entries buffered (2 or 4; pointer wrap relies on a power of 2)
//   NOP_INSTR  instruction word shown to decode while the buffer is empty
//
// Ports
//   clk            single clock, rising edge
//   reset          asynchronous, active-high; empties the buffer at once
//   if_valid       fetch presents an instruction
//   if_pc          fetch address
//   if_instr       fetched instruction word
//   if_ready       buffer has room (from registered occupancy only)
//   flush          discard buffered and incoming entries
//   id_ready       decode consumes the head entry
//   id_valid       head entry is valid
//   id_pc          head entry pc (0 when empty)
//   id_instr       head entry instruction (NOP_INSTR when empty)
//   id_pc_plus4    id_pc + 4, wrapping modulo 2^32
//   id_misaligned  head entry was fetched from a non word-aligned pc
// ---------------------------------------------------------------------------
module if_id_stage #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  output logic        if_ready,
  input  logic        flush,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_misaligned
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  logic            push;
  logic            pop;
  entry_t          wr_entry;
  entry_t          head;

  // Room and validity come only from the registered count, so neither
  // id_ready nor flush can reach if_ready combinationally.
  assign if_ready = (count_q < CW'(DEPTH));
  assign id_valid = (count_q != '0);

  assign push = if_valid && if_ready && !flush;
  assign pop  = id_valid && id_ready && !flush;

  always_comb begin
    wr_entry            = '0;
    wr_entry.pc         = if_pc;
    wr_entry.instr      = if_instr;
    wr_entry.misaligned = (if_pc[1:0] != 2'b00);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      // Emptying by aligning the read pointer to the write pointer keeps the
      // next push landing where the pointer already is.
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is modulo DEPTH.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = wr_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left uncleared; every output is gated by count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    id_pc         = 32'h0000_0000;
    id_instr      = NOP_INSTR;
    id_misaligned = 1'b0;
    if (id_valid) begin
      id_pc         = head.pc;
      id_instr      = head.instr;
      id_misaligned = head.misaligned;
    end
  end

  assign id_pc_plus4 = id_pc + 32'd4;

endmodule
